hamming_correct: RTL and testbench
==================================

Name: hamming_correct

Overview:
- Downstream SECDED decode stage. Consumes a received extended-Hamming codeword plus the raw syndrome and extended parity that the parity-generation stage computes over it.
- Classifies each word as clean, single-bit error or double-bit error, corrects single errors, strips the parity positions and delivers the DATA_WIDTH payload.
- Two-register valid/ready pipeline that sits between the parity stage and the consumer of the decoded data.

Parameters:
- DATA_WIDTH, 32, payload width. CODED_WIDTH and ADDR_WIDTH are derived from it by the team's hamming defines include; they are not overridable.
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  reset, synchronous and active-low
- in_valid_i  input  1  input word valid
- in_ready_o  output  1  stage can accept the input word
- coded_i  input  CODED_WIDTH  received codeword; bit 0 is the extended parity bit, power-of-two indices are parity bits
- syndrome_i  input  ADDR_WIDTH  XOR of the indices of all set bits of coded_i
- ext_parity_i  input  1  XOR of coded_i[CODED_WIDTH-1:1]
- out_valid_o  output  1  output word valid
- out_ready_i  input  1  consumer accepts the output word
- data_o  output  DATA_WIDTH  decoded payload
- single_err_o  output  1  word had a corrected single error
- double_err_o  output  1  word had an uncorrectable error
- err_pos_o  output  ADDR_WIDTH  corrected bit index; 0 when single_err_o=0
- clr_cnt_i  input  1  clear error counters
- single_cnt_o  output  CNT_WIDTH  corrected-error count
- double_cnt_o  output  CNT_WIDTH  uncorrectable-error count

Behaviour:
- Reset (rst_n_i=0 at a clock edge): both stage valids=0, out_valid_o=0, data_o=0, single_err_o=0, double_err_o=0, err_pos_o=0, counters=0. Any word in flight is dropped. in_ready_o=1 from the first cycle after reset.
- Stage 1 (classify), registered on input handshake (in_valid_i & in_ready_o):
  - overall = ext_parity_i ^ coded_i[0].
  - overall=0, syndrome=0: clean.
  - overall=1: single error at index syndrome_i. Index 0 means the extended parity bit itself.
  - overall=1 with syndrome_i >= CODED_WIDTH: double error.
  - overall=0, syndrome≠0: double error.
  - Registers the codeword, class and position.
- Stage 2 (correct/extract):
  - Single error: flip bit err_pos of the codeword.
  - Double error: no flip; data_o carries the uncorrected extraction.
  - data_o[k] = the k-th non-power-of-two, nonzero index in ascending order (e.g. data_o[0]=coded[3], data_o[1]=coded[5]).
- Flow control:
  - s2 loads when !s2_valid | out_ready_i.
  - s1 advances when !s1_valid | s2 loads.
  - in_ready_o = !s1_valid | s2 loads. This is a combinational path from out_ready_i.
- Latency: input handshake at cycle N gives out_valid_o at N+2 when unstalled. Throughput is 1 word/cycle.
- Stall: while out_valid_o=1 and out_ready_i=0, data_o and the flags hold stable. With both stages full, in_ready_o=0. No word is lost or duplicated.
- Flags are qualified by out_valid_o and have one-hot/zero encoding: never both single_err_o and double_err_o.
- Counters:
  - Increment on output handshake, per flag.
  - Saturate at all-ones.
  - clr_cnt_i clears; clear wins over a simultaneous increment.

Optional Feature:
- Macro HAMMING_CORRECT_CNT_EN.
- Defined: counters behave as specified above.
- Undefined: no counter flops are built; single_cnt_o and double_cnt_o are tied to 0 and clr_cnt_i is ignored. The ports remain present.

Test Plan:
All scenarios use DATA_WIDTH=4 (CODED_WIDTH=8, ADDR_WIDTH=3).
- Clean: coded_i=0xAA, syndrome_i=0, ext_parity_i=0 -> 2 cycles later data_o=0xB, both flags 0, err_pos_o=0.
- Single error: coded_i=0x8A, syndrome_i=5, ext_parity_i=1 -> data_o=0xB, single_err_o=1, err_pos_o=5, single_cnt_o=1.
- Parity-bit error: coded_i=0xAB, syndrome_i=0, ext_parity_i=0 -> data_o=0xB, single_err_o=1, err_pos_o=0.
- Double error: coded_i=0xCA, syndrome_i=3, ext_parity_i=0 -> data_o=0xD (uncorrected), double_err_o=1, double_cnt_o=1.
- Backpressure: stream 4 words, hold out_ready_i=0 for 5 cycles -> in_ready_o drops after 2 accepted words. Output holds stable. All 4 words later emerge in order with no loss or duplication.
- Reset/clear: assert rst_n_i=0 mid-stream -> out_valid_o=0 and counters=0 next cycle. Separately, clr_cnt_i=1 in the same cycle as a single-error handshake -> single_cnt_o=0.

Source files
------------

// File: rtl/hamming_correct.sv
// ---------------------------------------------------------------------------
// hamming_correct
//   SECDED decode stage for an extended-Hamming codeword. Classifies each
//   received word as clean / single error / double error, corrects single
//   errors, strips the parity positions and delivers the payload through a
//   two-register valid/ready pipeline (classify -> correct/extract).
//
//   Optional feature: define HAMMING_CORRECT_CNT_EN to build the saturating
//   error counters. When undefined the counter outputs are tied to zero and
//   clr_cnt_i is ignored; the ports stay present.
//
//   Ports
//     clk_i, rst_n_i      clock, synchronous active-low reset
//     in_valid_i/ready_o  input handshake (in_ready_o is combinational
//                         from out_ready_i)
//     coded_i             received codeword, bit 0 = extended parity,
//                         power-of-two indices = Hamming parity bits
//     syndrome_i          XOR of indices of all set bits of coded_i
//     ext_parity_i        XOR of coded_i[CODED_WIDTH-1:1]
//     out_valid_o/ready_i output handshake
//     data_o              decoded payload
//     single_err_o        corrected single error (position in err_pos_o)
//     double_err_o        uncorrectable error
//     err_pos_o           corrected bit index, 0 when no single error
//     clr_cnt_i           clear error counters
//     single_cnt_o        corrected-error count
//     double_cnt_o        uncorrectable-error count
// ---------------------------------------------------------------------------
module hamming_correct #(
   parameter  int unsigned DATA_WIDTH  = 32,
   parameter  int unsigned CNT_WIDTH   = 16,
   // Smallest r with 2^r >= DATA_WIDTH + r + 1 (two-step fixed point).
   localparam int unsigned PAR_BITS    = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
   localparam int unsigned CODED_WIDTH = DATA_WIDTH + PAR_BITS + 1,
   localparam int unsigned ADDR_WIDTH  = $clog2(CODED_WIDTH)
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [CODED_WIDTH-1:0] coded_i,
   input  logic [ADDR_WIDTH-1:0]  syndrome_i,
   input  logic                   ext_parity_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic                   single_err_o,
   output logic                   double_err_o,
   output logic [ADDR_WIDTH-1:0]  err_pos_o,
   input  logic                   clr_cnt_i,
   output logic [CNT_WIDTH-1:0]   single_cnt_o,
   output logic [CNT_WIDTH-1:0]   double_cnt_o
);

   // Codeword index of payload bit k: k-th nonzero, non-power-of-two index.
   function automatic int unsigned data_pos(input int unsigned k);
      int unsigned cnt;
      int unsigned pos;
      cnt = 0;
      pos = 0;
      for (int unsigned i = 1; i < CODED_WIDTH; i++) begin
         if ((i & (i - 1)) != 0) begin
            if (cnt == k) pos = i;
            cnt++;
         end
      end
      return pos;
   endfunction

   // Stage 1 registers
   logic                   s1_valid_q,  s1_valid_d;
   logic [CODED_WIDTH-1:0] s1_code_q,   s1_code_d;
   logic                   s1_single_q, s1_single_d;
   logic                   s1_double_q, s1_double_d;
   logic [ADDR_WIDTH-1:0]  s1_pos_q,    s1_pos_d;

   // Stage 2 (output) registers
   logic                   out_valid_q,  out_valid_d;
   logic [DATA_WIDTH-1:0]  data_q,       data_d;
   logic                   single_err_q, single_err_d;
   logic                   double_err_q, double_err_d;
   logic [ADDR_WIDTH-1:0]  err_pos_q,    err_pos_d;

   logic s2_load;
   logic s1_adv;
   logic overall;
   logic cls_single;
   logic cls_double;
   logic [CODED_WIDTH-1:0] flip_mask;
   logic [CODED_WIDTH-1:0] corrected;
   logic [DATA_WIDTH-1:0]  data_ext;
   logic                   unused_par;

   // Flow control: output stage loads when empty or drained this cycle
   assign s2_load    = !out_valid_q || out_ready_i;
   assign s1_adv     = !s1_valid_q || s2_load;
   assign in_ready_o = s1_adv;

   // Error classification of the incoming word
   always_comb begin
      overall    = ext_parity_i ^ coded_i[0];
      cls_single = 1'b0;
      cls_double = 1'b0;
      if (overall) begin
         // odd overall parity with an out-of-range syndrome cannot be one flip
         if (32'(syndrome_i) >= CODED_WIDTH) cls_double = 1'b1;
         else                                cls_single = 1'b1;
      end else if (syndrome_i != '0) begin
         cls_double = 1'b1;
      end
   end

   // Stage 1 next state
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_code_d   = s1_code_q;
      s1_single_d = s1_single_q;
      s1_double_d = s1_double_q;
      s1_pos_d    = s1_pos_q;
      if (s1_adv) begin
         s1_valid_d = in_valid_i;
         if (in_valid_i) begin
            s1_code_d   = coded_i;
            s1_single_d = cls_single;
            s1_double_d = cls_double;
            s1_pos_d    = cls_single ? syndrome_i : '0;
         end
      end
   end

   // Correction of single errors; double errors pass through uncorrected
   assign flip_mask = s1_single_q ? (CODED_WIDTH'(1) << s1_pos_q) : '0;
   assign corrected = s1_code_q ^ flip_mask;

   // Payload extraction, skipping index 0 and power-of-two indices
   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_extract
      localparam int unsigned POS = data_pos(k);
      assign data_ext[k] = corrected[POS];
   end

   // Parity positions are dropped after correction
   assign unused_par = ^corrected;

   // Stage 2 next state
   always_comb begin
      out_valid_d  = out_valid_q;
      data_d       = data_q;
      single_err_d = single_err_q;
      double_err_d = double_err_q;
      err_pos_d    = err_pos_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            data_d       = data_ext;
            single_err_d = s1_single_q;
            double_err_d = s1_double_q;
            err_pos_d    = s1_pos_q;
         end else begin
            single_err_d = 1'b0;
            double_err_d = 1'b0;
            err_pos_d    = '0;
         end
      end
   end

   // Pipeline registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1_valid_q   <= 1'b0;
         s1_code_q    <= '0;
         s1_single_q  <= 1'b0;
         s1_double_q  <= 1'b0;
         s1_pos_q     <= '0;
         out_valid_q  <= 1'b0;
         data_q       <= '0;
         single_err_q <= 1'b0;
         double_err_q <= 1'b0;
         err_pos_q    <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_code_q    <= s1_code_d;
         s1_single_q  <= s1_single_d;
         s1_double_q  <= s1_double_d;
         s1_pos_q     <= s1_pos_d;
         out_valid_q  <= out_valid_d;
         data_q       <= data_d;
         single_err_q <= single_err_d;
         double_err_q <= double_err_d;
         err_pos_q    <= err_pos_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign data_o       = data_q;
   assign single_err_o = single_err_q;
   assign double_err_o = double_err_q;
   assign err_pos_o    = err_pos_q;

`ifdef HAMMING_CORRECT_CNT_EN
   logic [CNT_WIDTH-1:0] single_cnt_q, single_cnt_d;
   logic [CNT_WIDTH-1:0] double_cnt_q, double_cnt_d;
   logic                 out_hs;

   // Saturating counters, clear has priority over increment
   always_comb begin
      out_hs       = out_valid_q && out_ready_i;
      single_cnt_d = single_cnt_q;
      double_cnt_d = double_cnt_q;
      if (clr_cnt_i) begin
         single_cnt_d = '0;
         double_cnt_d = '0;
      end else if (out_hs) begin
         if (single_err_q && !(&single_cnt_q)) single_cnt_d = single_cnt_q + CNT_WIDTH'(1);
         if (double_err_q && !(&double_cnt_q)) double_cnt_d = double_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         single_cnt_q <= '0;
         double_cnt_q <= '0;
      end else begin
         single_cnt_q <= single_cnt_d;
         double_cnt_q <= double_cnt_d;
      end
   end

   assign single_cnt_o = single_cnt_q;
   assign double_cnt_o = double_cnt_q;
`else
   logic unused_clr;
   assign unused_clr   = clr_cnt_i;
   assign single_cnt_o = '0;
   assign double_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hamming_correct.sv
// ---------------------------------------------------------------------------
// tb_hamming_correct
//   Directed bench for hamming_correct at DATA_WIDTH=4 (8-bit codeword,
//   3-bit syndrome). Counter expectations follow HAMMING_CORRECT_CNT_EN.
// ---------------------------------------------------------------------------
module tb_hamming_correct;

   localparam int unsigned DW = 4;
   localparam int unsigned CW = 8;
   localparam int unsigned AW = 3;
   localparam int unsigned NW = 16;
`ifdef HAMMING_CORRECT_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] coded;
   logic [AW-1:0] syndrome;
   logic          ext_parity;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] data;
   logic          single_err;
   logic          double_err;
   logic [AW-1:0] err_pos;
   logic          clr_cnt;
   logic [NW-1:0] single_cnt;
   logic [NW-1:0] double_cnt;

   int vecs = 0;
   int errs = 0;
   int exp_single = 0;
   int exp_double = 0;

   // Stream used by the backpressure scenario with its expected outputs
   logic [CW-1:0] wc [4] = '{8'hAA, 8'h8A, 8'hAB, 8'hCA};
   logic [AW-1:0] ws [4] = '{3'd0, 3'd5, 3'd0, 3'd3};
   logic          we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic [8:0]    ex [4] = '{{4'hB, 1'b0, 1'b0, 3'd0}, {4'hB, 1'b1, 1'b0, 3'd5},
                            {4'hB, 1'b1, 1'b0, 3'd0}, {4'hD, 1'b0, 1'b1, 3'd0}};

   always #5 clk = ~clk;

   hamming_correct #(.DATA_WIDTH(DW), .CNT_WIDTH(NW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .coded_i      (coded),
      .syndrome_i   (syndrome),
      .ext_parity_i (ext_parity),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .data_o       (data),
      .single_err_o (single_err),
      .double_err_o (double_err),
      .err_pos_o    (err_pos),
      .clr_cnt_i    (clr_cnt),
      .single_cnt_o (single_cnt),
      .double_cnt_o (double_cnt)
   );

   function automatic logic [NW-1:0] cnt_exp(input int n);
      return CNT_ON ? NW'(n) : '0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single cycle (caller checks in_ready first)
   task automatic drive_word(input logic [CW-1:0] c, input logic [AW-1:0] s, input logic e);
      coded = c; syndrome = s; ext_parity = e; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
      coded = '0; syndrome = '0; ext_parity = 1'b0;
      step(); step();
      rst_n = 1'b1;
      #1;
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      vecs++; if ({data, single_err, double_err, err_pos} !== 9'd0) begin errs++; $display("FAIL rst_outputs: got %h expected 000", {data, single_err, double_err, err_pos}); end
      vecs++; if ({single_cnt, double_cnt} !== 32'd0) begin errs++; $display("FAIL rst_counters: got %h expected 0", {single_cnt, double_cnt}); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      step();
   endtask

   task automatic test_clean();
      out_ready = 1'b1;
      coded = 8'hAA; syndrome = 3'd0; ext_parity = 1'b0; in_valid = 1'b1;
      #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL clean_in_ready: got %b expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL clean_latency1: out_valid got %b expected 0", out_valid); end
      step();
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL clean_latency2: out_valid got %b expected 1", out_valid); end
      vecs++; if ({data, single_err, double_err, err_pos} !== {4'hB, 1'b0, 1'b0, 3'd0}) begin errs++; $display("FAIL clean_word: got %h expected %h", {data, single_err, double_err, err_pos}, {4'hB, 1'b0, 1'b0, 3'd0}); end
      step();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL clean_drain: out_valid got %b expected 0", out_valid); end
      vecs++; if ({single_cnt, double_cnt} !== {cnt_exp(0), cnt_exp(0)}) begin errs++; $display("FAIL clean_counters: got %h expected 0", {single_cnt, double_cnt}); end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      drive_word(8'h8A, 3'd5, 1'b1);
      step();
      vecs++; if ({out_valid, data, single_err, double_err, err_pos} !== {1'b1, 4'hB, 1'b1, 1'b0, 3'd5}) begin errs++; $display("FAIL single_word: got %h expected %h", {out_valid, data, single_err, double_err, err_pos}, {1'b1, 4'hB, 1'b1, 1'b0, 3'd5}); end
      step();
      exp_single++;
      vecs++; if (single_cnt !== cnt_exp(exp_single)) begin errs++; $display("FAIL single_cnt: got %0d expected %0d", single_cnt, cnt_exp(exp_single)); end
   endtask

   task automatic test_parity_bit();
      out_ready = 1'b1;
      drive_word(8'hAB, 3'd0, 1'b0);
      step();
      vecs++; if ({out_valid, data, single_err, double_err, err_pos} !== {1'b1, 4'hB, 1'b1, 1'b0, 3'd0}) begin errs++; $display("FAIL parity_word: got %h expected %h", {out_valid, data, single_err, double_err, err_pos}, {1'b1, 4'hB, 1'b1, 1'b0, 3'd0}); end
      step();
      exp_single++;
      vecs++; if (single_cnt !== cnt_exp(exp_single)) begin errs++; $display("FAIL parity_cnt: got %0d expected %0d", single_cnt, cnt_exp(exp_single)); end
   endtask

   task automatic test_double();
      out_ready = 1'b1;
      drive_word(8'hCA, 3'd3, 1'b0);
      step();
      vecs++; if ({out_valid, data, single_err, double_err, err_pos} !== {1'b1, 4'hD, 1'b0, 1'b1, 3'd0}) begin errs++; $display("FAIL double_word: got %h expected %h", {out_valid, data, single_err, double_err, err_pos}, {1'b1, 4'hD, 1'b0, 1'b1, 3'd0}); end
      step();
      exp_double++;
      vecs++; if ({single_cnt, double_cnt} !== {cnt_exp(exp_single), cnt_exp(exp_double)}) begin errs++; $display("FAIL double_cnt: got %h expected %h", {single_cnt, double_cnt}, {cnt_exp(exp_single), cnt_exp(exp_double)}); end
   endtask

   task automatic test_backpressure();
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (sent < 4);
         if (sent < 4) begin
            coded = wc[sent]; syndrome = ws[sent]; ext_parity = we[sent];
         end
         #1;
         if (cyc < 5) begin
            vecs++; if (in_ready !== (cyc < 2)) begin errs++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", cyc, in_ready, (cyc < 2)); end
         end
         if (cyc >= 2 && cyc < 5) begin
            vecs++; if ({out_valid, data, single_err, double_err, err_pos} !== {1'b1, ex[0]}) begin errs++; $display("FAIL bp_hold: cycle %0d got %h expected %h", cyc, {out_valid, data, single_err, double_err, err_pos}, {1'b1, ex[0]}); end
         end
         if (out_valid && out_ready) begin
            vecs++; if ({data, single_err, double_err, err_pos} !== ex[got]) begin errs++; $display("FAIL bp_order: word %0d got %h expected %h", got, {data, single_err, double_err, err_pos}, ex[got]); end
            got++;
         end
         if (in_valid && in_ready) sent++;
         step();
      end
      in_valid = 1'b0;
      vecs++; if (got != 4) begin errs++; $display("FAIL bp_count: got %0d words expected 4", got); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_no_dup: out_valid got %b expected 0", out_valid); end
      exp_single += 2;
      exp_double += 1;
      vecs++; if ({single_cnt, double_cnt} !== {cnt_exp(exp_single), cnt_exp(exp_double)}) begin errs++; $display("FAIL bp_counters: got %h expected %h", {single_cnt, double_cnt}, {cnt_exp(exp_single), cnt_exp(exp_double)}); end
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      drive_word(8'h8A, 3'd5, 1'b1);
      step();
      vecs++; if ({out_valid, single_err} !== 2'b11) begin errs++; $display("FAIL clr_setup: got %b expected 11", {out_valid, single_err}); end
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      exp_single = 0;
      exp_double = 0;
      vecs++; if ({single_cnt, double_cnt} !== 32'd0) begin errs++; $display("FAIL clr_wins: got %h expected 0", {single_cnt, double_cnt}); end
      drive_word(8'h8A, 3'd5, 1'b1);
      step(); step();
      exp_single++;
      vecs++; if (single_cnt !== cnt_exp(exp_single)) begin errs++; $display("FAIL clr_recount: got %0d expected %0d", single_cnt, cnt_exp(exp_single)); end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      coded = 8'h8A; syndrome = 3'd5; ext_parity = 1'b1; in_valid = 1'b1;
      step(); step();
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL mid_setup: out_valid got %b expected 1", out_valid); end
      rst_n = 1'b0;
      step();
      vecs++; if ({out_valid, data, single_err, double_err, err_pos} !== 10'd0) begin errs++; $display("FAIL mid_rst_out: got %h expected 000", {out_valid, data, single_err, double_err, err_pos}); end
      vecs++; if ({single_cnt, double_cnt} !== 32'd0) begin errs++; $display("FAIL mid_rst_cnt: got %h expected 0", {single_cnt, double_cnt}); end
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
      for (int i = 0; i < 2; i++) begin
         step();
         vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_dropped: cycle %0d out_valid got %b expected 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single();
      test_parity_bit();
      test_double();
      test_backpressure();
      test_clear();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
